// File: rtl/cr_huf_comp_sim_is_nlane.sv
// Multi-lane Huffman simulated-size estimator: range-table bit-length lookup, saturating
// per-frame accumulation, per-frame LUT sweep, two-deep result buffer. Option: CR_HUF_COMP_SIM_IS_STATS_EN.
package cr_huf_comp_sim_is_nlane_pkg;
  typedef enum logic [1:0] {MIDDLE = 2'd0, END = 2'd1, PASS_END = 2'd2, FLUSH = 2'd3} e_pipe_eob;
endpackage

module cr_huf_comp_sim_is_nlane_lane #(
  parameter int DAT_WIDTH        = 10,
  parameter int CNT_WIDTH        = 3,
  parameter int NUM_RANGES       = 4,
  parameter int BL_WIDTH         = 5,
  parameter int MAX_NUM_SYM_USED = 576
) (
  input  logic                             vld,
  input  logic [DAT_WIDTH-1:0]             sym,
  input  logic [CNT_WIDTH-1:0]             cnt,
  input  logic [NUM_RANGES*DAT_WIDTH-1:0]  cfg_sym_lim,
  input  logic [NUM_RANGES*BL_WIDTH-1:0]   cfg_bl,
  output logic [BL_WIDTH+CNT_WIDTH-1:0]    prod
);
  localparam int PW = BL_WIDTH + CNT_WIDTH;

  logic                hit;
  logic [BL_WIDTH-1:0] bl;

  // Scan from the top so the lowest matching range wins.
  always_comb begin
    hit = 1'b0;
    bl  = '0;
    for (int k = NUM_RANGES - 1; k >= 0; k--) begin
      if (sym <= cfg_sym_lim[k*DAT_WIDTH +: DAT_WIDTH]) begin
        hit = 1'b1;
        bl  = cfg_bl[k*BL_WIDTH +: BL_WIDTH];
      end
    end
  end

  assign prod = (vld && hit && cnt != '0 && 32'(sym) < MAX_NUM_SYM_USED)
              ? PW'({{CNT_WIDTH{1'b0}}, bl} * {{BL_WIDTH{1'b0}}, cnt}) : '0;
endmodule

module cr_huf_comp_sim_is_nlane
  import cr_huf_comp_sim_is_nlane_pkg::*;
#(
  parameter int NUM_LANES        = 4,
  parameter int DAT_WIDTH        = 10,
  parameter int CNT_WIDTH        = 3,
  parameter int NUM_RANGES       = 4,
  parameter int BL_WIDTH         = 5,
  parameter int MAX_NUM_SYM_USED = 576,
  parameter int SIZE_WIDTH       = 20,
  parameter int SEQ_WIDTH        = 4,
  parameter int LUT_DEPTH        = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_LANES-1:0]            in_vld,
  input  logic [NUM_LANES*DAT_WIDTH-1:0]  in_sym,
  input  logic [NUM_LANES*CNT_WIDTH-1:0]  in_cnt,
  input  logic [SEQ_WIDTH-1:0]            in_seq_id,
  input  e_pipe_eob                       in_eob,
  output logic                            in_rd,
  input  logic [NUM_RANGES*DAT_WIDTH-1:0] cfg_sym_lim,
  input  logic [NUM_RANGES*BL_WIDTH-1:0]  cfg_bl,
  output logic                            lut_wr,
  output logic [$clog2(LUT_DEPTH)-1:0]    lut_wr_addr,
  output logic [1:0]                      lut_wr_val,
  output logic [SEQ_WIDTH-1:0]            lut_wr_seq_id,
  output logic                            lut_wr_done,
  output logic                            sz_vld,
  input  logic                            sz_rdy,
  output logic [SIZE_WIDTH-1:0]           sz_val,
  output logic [SEQ_WIDTH-1:0]            sz_seq_id,
  output e_pipe_eob                       sz_eob,
`ifdef CR_HUF_COMP_SIM_IS_STATS_EN
  output logic [15:0]                     stat_frames,
  output logic [15:0]                     stat_sat,
`endif
  output logic                            sz_ovf
);
  localparam int AW     = $clog2(LUT_DEPTH);
  localparam int PW     = BL_WIDTH + CNT_WIDTH;
  localparam int SUMW   = SIZE_WIDTH + $clog2(NUM_LANES + 1) + 1;
  localparam int STAGES = 3;

  typedef struct packed {
    logic [SIZE_WIDTH-1:0] val;
    logic [SEQ_WIDTH-1:0]  seq;
    e_pipe_eob             eob;
    logic                  ovf;
  } res_t;

  typedef enum logic [1:0] {IDLE, SWEEP, HOLD} state_t;

  logic [STAGES:1]                       vld_pipe;
  logic [SEQ_WIDTH-1:0]                  seq_pipe [1:STAGES];
  e_pipe_eob                             eob_pipe [1:STAGES];
  logic [NUM_LANES-1:0]                  s1_lane_vld;
  logic [NUM_LANES-1:0][DAT_WIDTH-1:0]   s1_sym;
  logic [NUM_LANES-1:0][CNT_WIDTH-1:0]   s1_cnt;
  logic [NUM_LANES-1:0][PW-1:0]          lane_prod, s2_prod;
  logic [SUMW-1:0]                       lane_sum, s3_sum;
  logic [SIZE_WIDTH-1:0]                 acc, new_acc;
  logic                                  acc_ovf, new_ovf, sat;
  logic [SUMW:0]                         acc_wide;
  res_t                                  slot [2];
  res_t                                  close_res;
  logic [1:0]                            slot_cnt, cnt_after_pop;
  logic                                  head_swept, accept, close, pop;
  logic [2:0]                            pending;
  state_t                                state, state_nx;
  logic [AW-1:0]                         addr;

  assign accept = (|in_vld) && in_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      s1_lane_vld <= '0;
      s1_sym      <= '0;
      s1_cnt      <= '0;
      s2_prod     <= '0;
      s3_sum      <= '0;
      for (int s = 1; s <= STAGES; s++) begin
        seq_pipe[s] <= '0;
        eob_pipe[s] <= MIDDLE;
      end
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], accept};
      seq_pipe[1] <= in_seq_id;
      eob_pipe[1] <= accept ? in_eob : MIDDLE;
      for (int s = 2; s <= STAGES; s++) begin
        seq_pipe[s] <= seq_pipe[s-1];
        eob_pipe[s] <= eob_pipe[s-1];
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        s1_lane_vld[i] <= accept && in_vld[i];
        s1_sym[i]      <= in_vld[i] ? in_sym[i*DAT_WIDTH +: DAT_WIDTH] : '0;
        s1_cnt[i]      <= in_vld[i] ? in_cnt[i*CNT_WIDTH +: CNT_WIDTH] : '0;
      end
      s2_prod <= lane_prod;
      s3_sum  <= lane_sum;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    cr_huf_comp_sim_is_nlane_lane #(
      .DAT_WIDTH(DAT_WIDTH), .CNT_WIDTH(CNT_WIDTH), .NUM_RANGES(NUM_RANGES),
      .BL_WIDTH(BL_WIDTH), .MAX_NUM_SYM_USED(MAX_NUM_SYM_USED)
    ) u_lane (
      .vld(s1_lane_vld[i]), .sym(s1_sym[i]), .cnt(s1_cnt[i]),
      .cfg_sym_lim(cfg_sym_lim), .cfg_bl(cfg_bl), .prod(lane_prod[i])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) lane_sum = lane_sum + SUMW'(s2_prod[i]);
  end

  // Sum is kept wide so a single beat can never wrap before the saturation test.
  assign acc_wide  = {1'b0, SUMW'(acc)} + {1'b0, s3_sum};
  assign sat       = |acc_wide[SUMW:SIZE_WIDTH];
  assign new_acc   = sat ? '1 : acc_wide[SIZE_WIDTH-1:0];
  assign new_ovf   = acc_ovf || sat;
  assign close     = vld_pipe[STAGES] && eob_pipe[STAGES] != MIDDLE;
  assign close_res = '{val: new_acc, seq: seq_pipe[STAGES], eob: eob_pipe[STAGES], ovf: new_ovf};
  assign pop       = sz_vld && sz_rdy;
  assign cnt_after_pop = slot_cnt - {1'b0, pop};

  // Pop is applied before the write so a closing frame always finds a free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      acc_ovf    <= 1'b0;
      slot[0]    <= '0;
      slot[1]    <= '0;
      slot_cnt   <= '0;
      head_swept <= 1'b0;
    end else begin
      if (vld_pipe[STAGES]) begin
        acc     <= close ? '0 : new_acc;
        acc_ovf <= close ? 1'b0 : new_ovf;
      end
      if (pop) slot[0] <= slot[1];
      if (close) slot[cnt_after_pop[0]] <= close_res;
      slot_cnt <= cnt_after_pop + {1'b0, close};
      if (pop) head_swept <= 1'b0;
      else if (lut_wr_done) head_swept <= 1'b1;
    end
  end

  always_comb begin
    pending = {1'b0, slot_cnt};
    for (int s = 1; s <= STAGES; s++)
      pending = pending + {2'b0, (vld_pipe[s] && eob_pipe[s] != MIDDLE)};
  end
  assign in_rd = pending < 3'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      state <= state_nx;
      addr  <= (state == SWEEP) ? addr + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (slot_cnt != '0 && !head_swept) state_nx = SWEEP;
      SWEEP:   if (addr == AW'(LUT_DEPTH - 1)) state_nx = HOLD;
      HOLD:    if (sz_rdy) state_nx = (cnt_after_pop != '0 || close) ? SWEEP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign lut_wr        = state == SWEEP;
  assign lut_wr_addr   = lut_wr ? addr : '0;
  assign lut_wr_val    = lut_wr ? 2'h3 : 2'h0;
  assign lut_wr_seq_id = lut_wr ? slot[0].seq : '0;
  assign lut_wr_done   = lut_wr && addr == AW'(LUT_DEPTH - 1);
  assign sz_vld        = state == HOLD;
  assign sz_val        = sz_vld ? slot[0].val : '0;
  assign sz_seq_id     = sz_vld ? slot[0].seq : '0;
  assign sz_eob        = sz_vld ? slot[0].eob : MIDDLE;
  assign sz_ovf        = sz_vld && slot[0].ovf;

`ifdef CR_HUF_COMP_SIM_IS_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_sat    <= '0;
    end else if (pop) begin
      stat_frames <= stat_frames + 16'd1;
      if (slot[0].ovf && stat_sat != 16'hFFFF) stat_sat <= stat_sat + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cr_huf_comp_sim_is_nlane.sv
// Directed bench for cr_huf_comp_sim_is_nlane, built with SIZE_WIDTH=8 so saturation is reachable.
module tb_cr_huf_comp_sim_is_nlane;
  import cr_huf_comp_sim_is_nlane_pkg::*;

  localparam int SW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_vld = '0;
  logic [39:0] in_sym = '0;
  logic [11:0] in_cnt = '0;
  logic [3:0]  in_seq_id = '0;
  e_pipe_eob   in_eob = MIDDLE;
  logic        in_rd;
  logic [39:0] cfg_sym_lim = {10'd575, 10'd279, 10'd255, 10'd143};
  logic [19:0] cfg_bl      = {5'd8, 5'd7, 5'd9, 5'd8};
  logic        lut_wr, lut_wr_done, sz_vld, sz_ovf;
  logic        sz_rdy = 1'b0;
  logic [7:0]  lut_wr_addr;
  logic [1:0]  lut_wr_val;
  logic [3:0]  lut_wr_seq_id, sz_seq_id;
  logic [SW-1:0] sz_val;
  e_pipe_eob   sz_eob;
`ifdef CR_HUF_COMP_SIM_IS_STATS_EN
  logic [15:0] stat_frames, stat_sat;
`endif

  always #5 clk = ~clk;

  cr_huf_comp_sim_is_nlane #(.SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_sym(in_sym), .in_cnt(in_cnt),
    .in_seq_id(in_seq_id), .in_eob(in_eob), .in_rd(in_rd),
    .cfg_sym_lim(cfg_sym_lim), .cfg_bl(cfg_bl),
    .lut_wr(lut_wr), .lut_wr_addr(lut_wr_addr), .lut_wr_val(lut_wr_val),
    .lut_wr_seq_id(lut_wr_seq_id), .lut_wr_done(lut_wr_done),
    .sz_vld(sz_vld), .sz_rdy(sz_rdy), .sz_val(sz_val), .sz_seq_id(sz_seq_id),
    .sz_eob(sz_eob),
`ifdef CR_HUF_COMP_SIM_IS_STATS_EN
    .stat_frames(stat_frames), .stat_sat(stat_sat),
`endif
    .sz_ovf(sz_ovf)
  );

  typedef struct {
    logic [SW-1:0] val;
    logic [3:0]    seq;
    logic [1:0]    eob;
    logic          ovf;
    int            lutcnt;
    int            donecnt;
    logic [3:0]    lseq;
  } res_t;

  res_t       res_q[$];
  int         lutcnt = 0, donecnt = 0, done_total = 0, lut_err = 0;
  logic [3:0] lseq = '0;
  int         n_vec = 0, n_mis = 0;

  // Records each popped result with the sweep activity seen since the previous pop.
  always @(negedge clk) begin
    if (!rst_n) begin
      lutcnt  = 0;
      donecnt = 0;
    end else begin
      if (lut_wr_done) done_total++;
      if (sz_vld && sz_rdy) begin
        res_q.push_back('{sz_val, sz_seq_id, sz_eob, sz_ovf, lutcnt, donecnt, lseq});
        lutcnt  = 0;
        donecnt = 0;
      end else if (lut_wr) begin
        if (lut_wr_addr != lutcnt[7:0] || lut_wr_val != 2'h3) lut_err++;
        if (lut_wr_done) donecnt++;
        lseq = lut_wr_seq_id;
        lutcnt++;
      end else if (lut_wr_val != 2'h0) lut_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] v, input logic [39:0] s, input logic [11:0] c,
                      input logic [3:0] q, input e_pipe_eob e);
    int n = 0;
    in_vld = v; in_sym = s; in_cnt = c; in_seq_id = q; in_eob = e;
    while (!in_rd && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_rd) chk("in_rd_timeout", {31'd0, in_rd}, 32'd1);
    @(posedge clk); #1;
    in_vld = '0;
    in_eob = MIDDLE;
  endtask

  task automatic wait_res(input int n);
    for (int i = 0; i < 3000 && res_q.size() < n; i++) @(posedge clk);
    #1;
    chk($sformatf("res_cnt_%0d", n), res_q.size(), n);
  endtask

  task automatic check_res(input int idx, input logic [SW-1:0] val, input logic [3:0] seq,
                           input e_pipe_eob eob, input logic ovf);
    res_t r;
    if (idx >= res_q.size()) begin
      chk($sformatf("r%0d_present", idx), res_q.size(), idx + 1);
      return;
    end
    r = res_q[idx];
    chk($sformatf("r%0d_val", idx), r.val, val);
    chk($sformatf("r%0d_seq", idx), r.seq, seq);
    chk($sformatf("r%0d_eob", idx), r.eob, eob);
    chk($sformatf("r%0d_ovf", idx), r.ovf, ovf);
    chk($sformatf("r%0d_lutcnt", idx), r.lutcnt, 256);
    chk($sformatf("r%0d_done", idx), r.donecnt, 1);
    chk($sformatf("r%0d_lutseq", idx), r.lseq, seq);
  endtask

  initial begin
    int dbefore;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rd", in_rd, 1);
    chk("rst_sz_vld", sz_vld, 0);
    chk("rst_lut_wr", lut_wr, 0);
    chk("rst_lut_done", lut_wr_done, 0);
    chk("rst_sz_val", sz_val, 0);
    chk("rst_sz_eob", sz_eob, MIDDLE);
    chk("rst_lut_addr", lut_wr_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single four-lane beat: 8+18+21+8
    sz_rdy = 1'b1;
    send(4'hF, {10'd300, 10'd260, 10'd200, 10'd10}, {3'd1, 3'd3, 3'd2, 3'd1}, 4'd5, END);
    wait_res(1);
    check_res(0, 8'd55, 4'd5, END, 1'b0);

    // Lane mask, sym >= 576 and cnt 0 all contribute nothing
    send(4'b0101, {10'd10, 10'd10, 10'd10, 10'd600}, {3'd7, 3'd0, 3'd7, 3'd3}, 4'd6, END);
    wait_res(2);
    check_res(1, 8'd0, 4'd6, END, 1'b0);

    // No matching range contributes nothing; sym on the top limit matches
    cfg_sym_lim = {10'd400, 10'd279, 10'd255, 10'd143};
    send(4'b0011, {10'd0, 10'd0, 10'd400, 10'd450}, {3'd0, 3'd0, 3'd2, 3'd5}, 4'd4, END);
    wait_res(3);
    check_res(2, 8'd16, 4'd4, END, 1'b0);
    cfg_sym_lim = {10'd575, 10'd279, 10'd255, 10'd143};

    // Back-to-back frames with downstream stalled
    sz_rdy = 1'b0;
    send(4'hF, {10'd0, 10'd0, 10'd0, 10'd0}, {3'd1, 3'd1, 3'd1, 3'd1}, 4'd1, MIDDLE);
    send(4'hF, {10'd256, 10'd255, 10'd144, 10'd143}, {3'd1, 3'd1, 3'd1, 3'd1}, 4'd1, END);
    send(4'hF, {10'd576, 10'd575, 10'd280, 10'd279}, {3'd7, 3'd2, 3'd2, 3'd2}, 4'd2, END);
    chk("in_rd_drop", in_rd, 0);
    repeat (600) @(posedge clk);
    #1;
    chk("in_rd_held", in_rd, 0);
    chk("hold_sz_vld", sz_vld, 1);
    chk("hold_sz_seq", sz_seq_id, 1);
    chk("hold_sz_val", sz_val, 65);
    chk("hold_no_pop", res_q.size(), 3);
    sz_rdy = 1'b1;
    send(4'b0001, {10'd1, 10'd1, 10'd1, 10'd1}, {3'd0, 3'd0, 3'd0, 3'd7}, 4'd3, END);
    wait_res(6);
    check_res(3, 8'd65, 4'd1, END, 1'b0);
    check_res(4, 8'd46, 4'd2, END, 1'b0);
    check_res(5, 8'd56, 4'd3, END, 1'b0);

    // Saturation over 40 beats of 224, then a clean frame
    for (int i = 0; i < 40; i++)
      send(4'hF, 40'd0, {3'd7, 3'd7, 3'd7, 3'd7}, 4'd7, (i == 39) ? PASS_END : MIDDLE);
    send(4'hF, 40'd0, {3'd1, 3'd1, 3'd1, 3'd1}, 4'd8, END);
    wait_res(8);
    check_res(6, 8'hFF, 4'd7, PASS_END, 1'b1);
    check_res(7, 8'd32, 4'd8, END, 1'b0);

    // Pop lands on the same edge as the next frame close
    sz_rdy = 1'b0;
    send(4'b0001, 40'd0, {3'd0, 3'd0, 3'd0, 3'd1}, 4'd11, END);
    for (int i = 0; i < 1000 && !sz_vld; i++) begin
      @(posedge clk); #1;
    end
    chk("d_hold", sz_vld, 1);
    send(4'b0011, {10'd0, 10'd0, 10'd144, 10'd143}, {3'd0, 3'd0, 3'd1, 3'd1}, 4'd12, END);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sz_rdy = 1'b1;
    @(posedge clk); #1;
    sz_rdy = 1'b0;
    chk("coinc_pop", res_q.size(), 9);
    send(4'hF, {10'd575, 10'd575, 10'd575, 10'd575}, {3'd1, 3'd1, 3'd1, 3'd1}, 4'd13, END);
    sz_rdy = 1'b1;
    wait_res(11);
    check_res(8, 8'd8, 4'd11, END, 1'b0);
    check_res(9, 8'd17, 4'd12, END, 1'b0);
    check_res(10, 8'd32, 4'd13, END, 1'b0);

    // Reset in the middle of a sweep
    send(4'hF, 40'd0, {3'd1, 3'd1, 3'd1, 3'd1}, 4'd14, END);
    for (int i = 0; i < 100 && !lut_wr; i++) begin
      @(posedge clk); #1;
    end
    repeat (50) @(posedge clk);
    #1;
    chk("mid_sweep", lut_wr, 1);
    dbefore = done_total;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_lut_wr", lut_wr, 0);
    chk("rst_mid_sz_vld", sz_vld, 0);
    chk("rst_mid_done", lut_wr_done, 0);
    chk("rst_mid_in_rd", in_rd, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("rst_no_done", done_total, dbefore);
    chk("rst_no_res", res_q.size(), 11);
    chk("rst_in_rd_after", in_rd, 1);
    send(4'hF, {10'd575, 10'd280, 10'd279, 10'd0}, {3'd1, 3'd1, 3'd1, 3'd1}, 4'd15, END);
    wait_res(12);
    check_res(11, 8'd31, 4'd15, END, 1'b0);

    chk("lut_stream", lut_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
